// File: rtl/button_press_counter.sv
// Push-button front end: 2-FF synchroniser, debounce FSM, single-cycle PRESS pulse and 8-bit press counter on LED7..LED0.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module button_press_counter #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int BTN_ACTIVE_LOW  = 0
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW1,
  output logic       PRESS,
  output logic       LED7,
  output logic       LED6,
  output logic       LED5,
  output logic       LED4,
  output logic       LED3,
  output logic       LED2,
  output logic       LED1,
  output logic       LED0,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DEB_P = 2'd1;
  localparam logic [1:0] HELD  = 2'd2;
  localparam logic [1:0] DEB_R = 2'd3;

  localparam int   DW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic REL = (BTN_ACTIVE_LOW != 0);

  logic          sync1;
  logic          sync2;
  logic          lvl;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          press_nxt;
  logic [DW-1:0] deb_cnt;
  logic          deb_done;
  logic [7:0]    count;

  // Sync FFs reset to the released pin level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= REL;
      sync2 <= REL;
    end else begin
      sync1 <= SW1;
      sync2 <= sync1;
    end
  end

  assign lvl      = sync2 ^ REL;
  assign deb_done = (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first_done;
  logic          rpt_hit;

  assign rpt_hit = rpt_first_done ? (rpt_cnt == RW'(REPEAT_PERIOD - 1))
                                  : (rpt_cnt == RW'(REPEAT_DELAY - 1));

  // Any exit from HELD (and the cycle of entry) restarts the initial delay.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
    end else if (state != HELD || state_nxt != HELD) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
    end else if (rpt_hit) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    press_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (lvl) state_nxt = DEB_P;
      end
      DEB_P: begin
        if (!lvl) begin
          state_nxt = IDLE;
        end else if (deb_done) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
        end
      end
      HELD: begin
        if (!lvl) begin
          state_nxt = DEB_R;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_hit) begin
          press_nxt = 1'b1;
        end
`endif
      end
      DEB_R: begin
        if (lvl) begin
          state_nxt = HELD;
        end else if (deb_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      deb_cnt <= '0;
      PRESS   <= 1'b0;
      count   <= 8'd0;
    end else begin
      state <= state_nxt;
      PRESS <= press_nxt;
      if (state_nxt != state) begin
        deb_cnt <= '0;
      end else if (state == DEB_P || state == DEB_R) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      if (PRESS) count <= count + 8'd1;
    end
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = count;
  assign fsm_state = state;

endmodule

// File: tb/tb_button_press_counter.sv
// Bench for button_press_counter: run-length reference model checked every cycle, a vector table and directed corner cases.
// Define AUTO_REPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_button_press_counter;

  localparam int D = 4;
`ifdef AUTO_REPEAT_EN
  localparam int R_DELAY  = 20;
  localparam int R_PERIOD = 8;
  localparam int RPT      = 1;
`else
  localparam int RPT      = 0;
`endif

  logic       CLK;
  logic       RST_N;
  logic       SW1;
  logic       PRESS;
  logic       LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0;
  logic [1:0] fsm_state;
  logic [7:0] leds;

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  button_press_counter #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW(0)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(R_DELAY),
    .REPEAT_PERIOD(R_PERIOD)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .SW1(SW1), .PRESS(PRESS),
    .LED7(LED7), .LED6(LED6), .LED5(LED5), .LED4(LED4),
    .LED3(LED3), .LED2(LED2), .LED1(LED1), .LED0(LED0),
    .fsm_state(fsm_state)
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int press_seen = 0;
  logic prev_press = 1'b0;

  // Reference model: the accepted level flips once D+1 consecutive synced samples disagree with it.
  logic       hist[$];
  logic       acc;
  int         run;
  int         hold_t;
  logic       exp_press;
  logic [7:0] exp_count;

  // scoreboard of expected press offsets for the hold test
  int exp_q[$];
  int got_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    hist = '{1'b0, 1'b0};
    acc = 1'b0;
    run = 0;
    hold_t = 0;
    exp_press = 1'b0;
    exp_count = 8'd0;
  endtask

  task automatic model_step(input logic sw);
    logic v;
    logic np;
    if (!RST_N) begin
      model_reset();
      return;
    end
    v = hist.pop_front();
    hist.push_back(sw);
    if (exp_press) exp_count = exp_count + 8'd1;
    np = 1'b0;
    if (v != acc) begin
      run++;
      hold_t = 0;
      if (run == D + 1) begin
        acc = v;
        run = 0;
        np = v;
      end
    end else if (run > 0) begin
      run = 0;
      hold_t = 0;
    end else if (acc) begin
      hold_t++;
`ifdef AUTO_REPEAT_EN
      if (hold_t == R_DELAY || (hold_t > R_DELAY && (hold_t - R_DELAY) % R_PERIOD == 0))
        np = 1'b1;
`endif
    end
    exp_press = np;
  endtask

  // driver: one clock cycle with SW1 = sw, compared against the model after the edge
  task automatic tick(input logic sw);
    SW1 = sw;
    @(posedge CLK);
    model_step(sw);
    @(negedge CLK);
    cyc++;
    check("model_press", int'(PRESS), int'(exp_press));
    check("model_leds", int'(leds), int'(exp_count));
    if (PRESS) begin
      press_seen++;
      check("no_back_to_back", int'(prev_press), 0);
    end
    prev_press = PRESS;
  endtask

  task automatic hold(input logic sw, input int n);
    for (int i = 0; i < n; i++) tick(sw);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    hold(1'b0, 3);
    check("reset_press", int'(PRESS), 0);
    check("reset_leds", int'(leds), 0);
    check("reset_state", int'(fsm_state), 0);
    RST_N = 1'b1;
    cyc = 0;
  endtask

  typedef struct {
    int hi;
    int lo;
    int exp_delta;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int p0;
    logic [7:0] l0;
    logic [7:0] diff;
    logic exp1;
    logic seen;

    tbl[0] = '{hi: 1,  lo: 8,  exp_delta: 0};
    tbl[1] = '{hi: 3,  lo: 8,  exp_delta: 0};
    tbl[2] = '{hi: 4,  lo: 8,  exp_delta: 0};
    tbl[3] = '{hi: 5,  lo: 8,  exp_delta: 1};
    tbl[4] = '{hi: 6,  lo: 8,  exp_delta: 1};
    tbl[5] = '{hi: 12, lo: 8,  exp_delta: 1};
    tbl[6] = '{hi: 24, lo: 8,  exp_delta: 1};
    tbl[7] = '{hi: 25, lo: 8,  exp_delta: 1 + RPT};
    tbl[8] = '{hi: 40, lo: 10, exp_delta: 1 + 2 * RPT};

    SW1 = 1'b0;
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);

    // 1: press sampled from edge 10, held 30 cycles
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      tick((k >= 10 && k <= 39) ? 1'b1 : 1'b0);
      exp1 = (k == 16) || (RPT == 1 && k == 36);
      check("t1_press_timing", int'(PRESS), int'(exp1));
    end
    check("t1_leds", int'(leds), 1 + RPT);

    // 2: short pulses are rejected
    do_reset();
    p0 = press_seen;
    for (int i = 0; i < 10; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 10);
    end
    check("t2_no_press", press_seen - p0, 0);
    check("t2_leds", int'(leds), 0);

    // 3: bounce on make and on release
    do_reset();
    p0 = press_seen;
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 12);
    hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 12);
    check("t3_one_press", press_seen - p0, 1);
    check("t3_leds", int'(leds), 1);

    // vector table: pulse widths around the debounce boundary
    do_reset();
    for (int i = 0; i < 9; i++) begin
      p0 = press_seen;
      l0 = leds;
      hold(1'b1, tbl[i].hi);
      hold(1'b0, tbl[i].lo);
      diff = leds - l0;
      check("tbl_presses", press_seen - p0, tbl[i].exp_delta);
      check("tbl_leds", int'(diff), tbl[i].exp_delta);
    end

    // 4: counter wrap
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      hold(1'b1, 6);
      hold(1'b0, 6);
      if (i == 255) check("t4_leds_ff", int'(leds), 255);
    end
    check("t4_wrap_zero", int'(leds), 0);

    // 5: reset during DEB_P with the button still down
    do_reset();
    hold(1'b1, 6);
    hold(1'b0, 8);
    check("t5_pre_leds", int'(leds), 1);
    hold(1'b1, 4);
    RST_N = 1'b0;
    model_reset();
    #1;
    check("t5_async_leds", int'(leds), 0);
    check("t5_async_press", int'(PRESS), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check("t5_rst_leds", int'(leds), 0);
      check("t5_rst_press", int'(PRESS), 0);
    end
    RST_N = 1'b1;
    cyc = 0;
    // same N+2+D latency, N = first edge after release
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1);
      check("t5_redebounce", int'(PRESS), (k == 3 + D) ? 1 : 0);
    end
    hold(1'b0, 10);

    // 6: long hold, press offsets against expected queue
    do_reset();
    hold(1'b0, 2);
    exp_q.delete();
    got_q.delete();
    exp_q.push_back(0);
    if (RPT == 1) begin
      exp_q.push_back(20); exp_q.push_back(28); exp_q.push_back(36);
      exp_q.push_back(44); exp_q.push_back(52);
    end
    for (int k = 0; k < 72; k++) begin
      tick((k < 60) ? 1'b1 : 1'b0);
      if (PRESS) got_q.push_back(cyc);
    end
    check("t6_press_count", got_q.size(), exp_q.size());
    seen = (got_q.size() > 0);
    if (seen) begin
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check("t6_press_offset", got_q[i] - got_q[0], exp_q[i]);
    end

    // randomized runs against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      hold(i[0] ? 1'b0 : 1'b1, $urandom_range(1, (RPT == 1) ? 40 : 12));
    end
    hold(1'b0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
